// File: rtl/baseband_sample_feed.sv
// Byte FIFO plus a two-sample hold register that replays packed 3-bit baseband samples, one every CLK_DIV clocks.
// Output latency: first sample on the first tick at/after two edges past the write; writes are dropped (sticky overflow) when full.
module baseband_sample_feed #(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [7:0]                 dataIn,
  input  logic                       dataValid,
  output logic                       dataReady,
  output logic [2:0]                 baseband,
  output logic                       basebandValid,
  output logic [$clog2(DEPTH):0]     fifoLevel,
  output logic                       overflow,
  output logic [15:0]                underflowCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic {HOLD_EMPTY, HOLD_LOADED} hold_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] tick_cnt;
  logic [7:0]    hold_byte;
  logic          phase, phase_nxt;
  logic          started;
  logic          wr_en, pop, tick, emit;
  hold_state_t   hold_state, hold_state_nxt;

  assign dataReady = (level != FULL);
  assign wr_en     = dataValid & dataReady;
  assign tick      = enable & (tick_cnt == CNT_LAST);
  assign fifoLevel = level;

  // Refill is gated by enable so a paused feed keeps the whole backlog in the FIFO.
  always_comb begin
    pop            = 1'b0;
    emit           = 1'b0;
    hold_state_nxt = hold_state;
    phase_nxt      = phase;
    case (hold_state)
      HOLD_EMPTY: begin
        if (enable && level != '0) begin
          pop            = 1'b1;
          hold_state_nxt = HOLD_LOADED;
          phase_nxt      = 1'b0;
        end
      end
      HOLD_LOADED: begin
        if (tick) begin
          emit = 1'b1;
          if (!phase) phase_nxt = 1'b1;
          else        hold_state_nxt = HOLD_EMPTY;
        end
      end
      default: hold_state_nxt = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_state <= HOLD_EMPTY;
      phase      <= 1'b0;
    end else begin
      hold_state <= hold_state_nxt;
      phase      <= phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dataIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      hold_byte      <= '0;
      tick_cnt       <= '0;
      started        <= 1'b0;
      baseband       <= '0;
      basebandValid  <= 1'b0;
      overflow       <= 1'b0;
      underflowCount <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (dataValid && !dataReady) overflow <= 1'b1;
      if (pop) begin
        hold_byte <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (enable) tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CW'(1);
      basebandValid <= emit;
      if (emit) begin
        baseband <= phase ? hold_byte[6:4] : hold_byte[2:0];
        started  <= 1'b1;
      end
      // Starved slots only count once the stream has actually begun.
      if (tick && hold_state == HOLD_EMPTY && started && underflowCount != 16'hFFFF)
        underflowCount <= underflowCount + 16'd1;
    end
  end

endmodule

// File: doc/baseband_sample_feed.md
# baseband_sample_feed

Buffers packed GPS baseband bytes written by the NIOS data-feed port and replays them as a paced stream of 3-bit samples for the tracking channel's `basebandInput`. Each byte carries two samples. The block sits between the `data_feed_nios` output port and `Track`. It replaces software bit-banging of the sample clock with a hardware FIFO, a fixed-rate sample strobe, and overflow and underflow reporting.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥ 4.
- `CLK_DIV`, 3: clocks per output sample; ≥ 2.

Ports:
- `clk`, in, 1: single clock; every register is clocked on its rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `enable`, in, 1: when low, sample pacing freezes; FIFO writes are still accepted.
- `dataIn`, in, 8: packed byte. Sample 0 is `[2:0]`, sample 1 is `[6:4]`. Bits 3 and 7 are ignored.
- `dataValid`, in, 1: write strobe, one byte per cycle.
- `dataReady`, out, 1: FIFO not full (combinational from the level).
- `baseband`, out, 3: current sample, held between strobes.
- `basebandValid`, out, 1: one-cycle pulse on each new sample.
- `fifoLevel`, out, $clog2(DEPTH)+1: bytes stored.
- `overflow`, out, 1: sticky; a byte was dropped.
- `underflowCount`, out, 16: saturating count of starved sample slots.

## Operation
- **FIFO write**
  - Each cycle with `dataValid & dataReady`, `dataIn` is written and `fifoLevel` increments.
  - `dataValid` while full drops the byte and sets `overflow`. `overflow` stays set until `reset`.
- **Hold register**
  - The hold register has a state bit (`empty` or `loaded`) and a `phase` bit (0 or 1).
  - When `empty` and the FIFO is non-empty, it pops one byte: state becomes `loaded`, `phase` becomes 0, and `fifoLevel` decrements.
  - A pop and a write in the same cycle leave `fifoLevel` unchanged.
- **Pacing**
  - A tick counter runs 0 to CLK_DIV-1 while `enable` is high. It wraps to 0, and a tick occurs in the cycle where the counter equals CLK_DIV-1.
  - When `enable` is low, the counter holds and no ticks occur.
- **On a tick with hold `loaded`**
  - `baseband` takes sample[`phase`] and `basebandValid` pulses.
  - If `phase`=0, `phase` becomes 1.
  - If `phase`=1, the hold becomes `empty`.
  - The `started` flag is set.
- **On a tick with hold `empty`**
  - `basebandValid` stays low and `baseband` holds its value.
  - If `started`=1, `underflowCount` increments, saturating at 16'hFFFF.
  - No underflow is counted before the first sample is emitted.
- **Order:** samples leave in byte order, sample 0 before sample 1.
- **Reset values:** `baseband`=0, `basebandValid`=0, `fifoLevel`=0, `dataReady`=1, `overflow`=0, `underflowCount`=0. Also reset: tick counter 0, hold `empty`, `started`=0, FIFO pointers 0.
- **Reset mid-stream** discards all buffered bytes and any half-used hold byte.

## Timing
- **Write to FIFO:** a byte accepted at edge N is poppable at edge N+1. The hold is `loaded` after edge N+1.
- **Refill vs. consumption:** the hold refills the cycle after it empties. Because CLK_DIV ≥ 2, a non-empty FIFO never causes a gap between output samples.
- **Output latency:** the first sample appears on the first tick occurring at or after edge N+2.
- **`dataReady`** reflects the level after the previous edge. A pop in the same cycle does not raise `dataReady` early.
- **Outputs:** `basebandValid` and `baseband` are registered and change together on the tick edge.
- **Sample rate:** one sample every CLK_DIV cycles (16.7 MS/s at 50 MHz, CLK_DIV=3).

## Test plan
- **Basic ordering:** after reset, write 8'h52 then 8'h31 with `enable`=1 and CLK_DIV=3. Required: `basebandValid` pulses exactly 3 cycles apart, and `baseband` reads 2, 5, 1, 3.
- **Overflow:** with `enable`=0, write 17 bytes into DEPTH=16. Required:
  - `dataReady` falls after the 16th write and `fifoLevel`=16.
  - The 17th byte is dropped and `overflow`=1.
  - After `enable`=1, exactly 32 samples emerge.
- **Underflow counting:** write one byte, then let 5 further ticks elapse with no writes. Required: 2 samples, then `underflowCount`=5. With no writes ever after reset, `underflowCount` stays 0.
- **Simultaneous write and pop:** with `fifoLevel`=1 and the hold `empty`, assert a write in the same cycle as the pop. Required: `fifoLevel` remains 1 and order is preserved.
- **Reset mid-stream:** assert `reset` asynchronously between edges partway through a byte (after sample 0 has been emitted). Required: all outputs at reset values immediately. After release, the next byte written yields its sample 0 first.
- **Enable pause:** drop `enable` for 10 cycles mid-stream. Required: no `basebandValid` pulses during the pause, no underflow counted, and the sample sequence resumes without loss.
